// File: rtl/rrf_pkg.sv
// Shared types and sizing for the rename register file state table.
// Also holds the operand lookup helper that implements writeback bypass.
package rrf_pkg;

    localparam int NUM_RRF = 8;
    localparam int TAG_W   = 3;
    localparam int DATA_W  = 32;

    typedef logic [TAG_W-1:0]  rrf_tag_t;
    typedef logic [DATA_W-1:0] rrf_data_t;

    typedef struct packed {
        logic      valid;
        rrf_data_t data;
    } rrf_rd_t;

    // Operand lookup: a same-cycle writeback makes a busy entry readable, wb0 wins over wb1.
    function automatic rrf_rd_t rrf_lookup(
        input rrf_tag_t  tag,
        input logic      entry_busy,
        input logic      entry_valid,
        input rrf_data_t entry_data,
        input logic      wb0_en,
        input rrf_tag_t  wb0_tag,
        input rrf_data_t wb0_data,
        input logic      wb1_en,
        input rrf_tag_t  wb1_tag,
        input rrf_data_t wb1_data
    );
        rrf_rd_t rd;
        logic    hit0;
        logic    hit1;
        hit0     = wb0_en && (wb0_tag == tag);
        hit1     = wb1_en && (wb1_tag == tag);
        rd.valid = entry_busy && (entry_valid || hit0 || hit1);
        if (hit0) begin
            rd.data = wb0_data;
        end else if (hit1) begin
            rd.data = wb1_data;
        end else begin
            rd.data = entry_data;
        end
        return rd;
    endfunction

endpackage

// File: rtl/rrf_state_table_if.sv
// Dispatch / execute / commit / lookup bundle of the RRF state table.
// master drives requests (pipeline side), slave is the state table.
interface rrf_state_table_if;
    import rrf_pkg::*;

    logic [0:NUM_RRF-1] free_rrf;
    logic               alloc0_en;
    logic               alloc1_en;
    rrf_tag_t           alloc0_tag;
    rrf_tag_t           alloc1_tag;
    logic               wb0_en;
    logic               wb1_en;
    rrf_tag_t           wb0_tag;
    rrf_tag_t           wb1_tag;
    rrf_data_t          wb0_data;
    rrf_data_t          wb1_data;
    logic               cm0_en;
    logic               cm1_en;
    rrf_tag_t           cm0_tag;
    rrf_tag_t           cm1_tag;
    rrf_data_t          cm0_data;
    rrf_data_t          cm1_data;
    rrf_tag_t           rd0_tag;
    rrf_tag_t           rd1_tag;
    logic               rd0_valid;
    logic               rd1_valid;
    rrf_data_t          rd0_data;
    rrf_data_t          rd1_data;
    logic               flush;
    logic               err;

    modport master (
        output alloc0_en, alloc1_en, alloc0_tag, alloc1_tag,
        output wb0_en, wb1_en, wb0_tag, wb1_tag, wb0_data, wb1_data,
        output cm0_en, cm1_en, cm0_tag, cm1_tag,
        output rd0_tag, rd1_tag, flush,
        input  free_rrf, cm0_data, cm1_data,
        input  rd0_valid, rd1_valid, rd0_data, rd1_data, err
    );

    modport slave (
        input  alloc0_en, alloc1_en, alloc0_tag, alloc1_tag,
        input  wb0_en, wb1_en, wb0_tag, wb1_tag, wb0_data, wb1_data,
        input  cm0_en, cm1_en, cm0_tag, cm1_tag,
        input  rd0_tag, rd1_tag, flush,
        output free_rrf, cm0_data, cm1_data,
        output rd0_valid, rd1_valid, rd0_data, rd1_data, err
    );

endinterface

// File: rtl/rrf_entry.sv
// One rename register: busy/valid/data state with same-entry conflict resolution.
// Request vectors are already decoded to this entry; bit 0 is port 0.
module rrf_entry
    import rrf_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       flush,
    input  logic [1:0] alloc_req,
    input  logic [1:0] wb_req,
    input  logic [1:0] cm_req,
    input  rrf_data_t  wb0_data,
    input  rrf_data_t  wb1_data,
    output logic       busy,
    output logic       valid,
    output rrf_data_t  data,
    output logic       illegal
);

    logic      busy_r;
    logic      valid_r;
    rrf_data_t data_r;
    logic      alloc_ok_s;
    logic      wb_ok_s;
    logic      cm_ok_s;
    logic      busy_nxt_s;
    logic      valid_nxt_s;
    rrf_data_t data_nxt_s;

    // Resolve which request takes effect; commit beats alloc, alloc beats wb, wb beats commit.
    always_comb begin
        alloc_ok_s = (|alloc_req) && !busy_r && !(|cm_req);
        wb_ok_s    = (|wb_req) && busy_r && !valid_r && !(|alloc_req);
        cm_ok_s    = (|cm_req) && valid_r && !(|wb_req);
        illegal    = ((|alloc_req) && !alloc_ok_s) || (&alloc_req)
                  || ((|wb_req) && !wb_ok_s)       || (&wb_req)
                  || ((|cm_req) && !cm_ok_s)       || (&cm_req);
    end

    // Next-state selection; the ok flags are mutually exclusive by construction.
    always_comb begin
        busy_nxt_s  = busy_r;
        valid_nxt_s = valid_r;
        data_nxt_s  = data_r;
        if (flush) begin
            busy_nxt_s  = 1'b0;
            valid_nxt_s = 1'b0;
        end else if (alloc_ok_s) begin
            busy_nxt_s  = 1'b1;
            valid_nxt_s = 1'b0;
        end else if (wb_ok_s) begin
            valid_nxt_s = 1'b1;
            data_nxt_s  = wb_req[0] ? wb0_data : wb1_data;
        end else if (cm_ok_s) begin
            busy_nxt_s  = 1'b0;
            valid_nxt_s = 1'b0;
        end else begin
            busy_nxt_s  = busy_r;
            valid_nxt_s = valid_r;
        end
    end

    // Entry state flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_r  <= 1'b0;
            valid_r <= 1'b0;
            data_r  <= '0;
        end else begin
            busy_r  <= busy_nxt_s;
            valid_r <= valid_nxt_s;
            data_r  <= data_nxt_s;
        end
    end

    assign busy  = busy_r;
    assign valid = valid_r;
    assign data  = data_r;

endmodule

// File: rtl/rrf_state_table.sv
// Rename register file state table: tag decode into NUM_RRF entries, read/commit
// muxes with writeback bypass, and the registered illegal-request pulse.
module rrf_state_table
    import rrf_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    rrf_state_table_if.slave   bus
);

    logic [0:NUM_RRF-1] busy_s;
    logic [0:NUM_RRF-1] valid_s;
    logic [0:NUM_RRF-1] illegal_s;
    rrf_data_t          data_s [NUM_RRF];
    rrf_rd_t            rd0_s;
    rrf_rd_t            rd1_s;
    logic               err_r;

    for (genvar j = 0; j < NUM_RRF; j++) begin : g_entry
        logic [1:0] alloc_req_s;
        logic [1:0] wb_req_s;
        logic [1:0] cm_req_s;

        assign alloc_req_s = {bus.alloc1_en && (bus.alloc1_tag == rrf_tag_t'(j)),
                              bus.alloc0_en && (bus.alloc0_tag == rrf_tag_t'(j))};
        assign wb_req_s    = {bus.wb1_en && (bus.wb1_tag == rrf_tag_t'(j)),
                              bus.wb0_en && (bus.wb0_tag == rrf_tag_t'(j))};
        assign cm_req_s    = {bus.cm1_en && (bus.cm1_tag == rrf_tag_t'(j)),
                              bus.cm0_en && (bus.cm0_tag == rrf_tag_t'(j))};

        rrf_entry u_entry (
            .clk       (clk),
            .rst       (rst),
            .flush     (bus.flush),
            .alloc_req (alloc_req_s),
            .wb_req    (wb_req_s),
            .cm_req    (cm_req_s),
            .wb0_data  (bus.wb0_data),
            .wb1_data  (bus.wb1_data),
            .busy      (busy_s[j]),
            .valid     (valid_s[j]),
            .data      (data_s[j]),
            .illegal   (illegal_s[j])
        );
    end

    // Error pulse: one cycle per offending cycle, suppressed by flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_r <= 1'b0;
        end else if (bus.flush) begin
            err_r <= 1'b0;
        end else begin
            err_r <= |illegal_s;
        end
    end

    // free_rrf comes straight from the busy flops so the picker never sees this cycle's allocs.
    assign bus.free_rrf = ~busy_s;
    assign bus.err      = err_r;
    assign bus.cm0_data = data_s[bus.cm0_tag];
    assign bus.cm1_data = data_s[bus.cm1_tag];

    assign rd0_s = rrf_lookup(bus.rd0_tag, busy_s[bus.rd0_tag], valid_s[bus.rd0_tag],
                              data_s[bus.rd0_tag], bus.wb0_en, bus.wb0_tag, bus.wb0_data,
                              bus.wb1_en, bus.wb1_tag, bus.wb1_data);
    assign rd1_s = rrf_lookup(bus.rd1_tag, busy_s[bus.rd1_tag], valid_s[bus.rd1_tag],
                              data_s[bus.rd1_tag], bus.wb0_en, bus.wb0_tag, bus.wb0_data,
                              bus.wb1_en, bus.wb1_tag, bus.wb1_data);

    assign bus.rd0_valid = rd0_s.valid;
    assign bus.rd0_data  = rd0_s.data;
    assign bus.rd1_valid = rd1_s.valid;
    assign bus.rd1_data  = rd1_s.data;

endmodule

// File: tb/tb_rrf_state_table.sv
// Directed-vector bench for rrf_state_table with hand-computed expectations.
// free_rrf is compared as an 8-bit value with entry 0 in the leftmost bit.
module tb_rrf_state_table;
    import rrf_pkg::*;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_miss;

    rrf_state_table_if bus ();

    rrf_state_table dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    task automatic drive_idle;
        bus.alloc0_en  = 1'b0;
        bus.alloc1_en  = 1'b0;
        bus.alloc0_tag = 3'd0;
        bus.alloc1_tag = 3'd0;
        bus.wb0_en     = 1'b0;
        bus.wb1_en     = 1'b0;
        bus.wb0_tag    = 3'd0;
        bus.wb1_tag    = 3'd0;
        bus.wb0_data   = 32'h0;
        bus.wb1_data   = 32'h0;
        bus.cm0_en     = 1'b0;
        bus.cm1_en     = 1'b0;
        bus.cm0_tag    = 3'd0;
        bus.cm1_tag    = 3'd0;
        bus.flush      = 1'b0;
        #1;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_vec       = 0;
        n_miss      = 0;
        rst         = 1'b1;
        bus.rd0_tag = 3'd0;
        bus.rd1_tag = 3'd0;
        drive_idle();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;

        chk_val("rst_free", 32'(bus.free_rrf), 32'h0000_00ff);
        chk_val("rst_err", 32'(bus.err), 32'h0);
        for (int t = 0; t < 8; t++) begin
            tick();
            bus.rd0_tag = 3'(t);
            #1;
            chk_val("rst_rd_valid", 32'(bus.rd0_valid), 32'h0);
        end

        // alloc tags 0 and 1
        bus.alloc0_en = 1'b1; bus.alloc0_tag = 3'd0;
        bus.alloc1_en = 1'b1; bus.alloc1_tag = 3'd1;
        tick(); drive_idle();
        chk_val("alloc_free", 32'(bus.free_rrf), 32'h0000_003f);
        chk_val("alloc_err", 32'(bus.err), 32'h0);
        tick();

        // writeback tag 0, bypass visible in the same cycle
        bus.wb0_en = 1'b1; bus.wb0_tag = 3'd0; bus.wb0_data = 32'hdead_beef;
        bus.rd0_tag = 3'd0; bus.rd1_tag = 3'd1;
        #1;
        chk_val("byp_valid", 32'(bus.rd0_valid), 32'h1);
        chk_val("byp_data", bus.rd0_data, 32'hdead_beef);
        chk_val("busy_nowb_valid", 32'(bus.rd1_valid), 32'h0);
        tick(); drive_idle();
        chk_val("stored_valid", 32'(bus.rd0_valid), 32'h1);
        chk_val("stored_data", bus.rd0_data, 32'hdead_beef);
        chk_val("wb_err", 32'(bus.err), 32'h0);

        // commit tag 0 with alloc tag 2
        bus.cm0_en = 1'b1; bus.cm0_tag = 3'd0;
        bus.alloc0_en = 1'b1; bus.alloc0_tag = 3'd2;
        #1;
        chk_val("cm0_data", bus.cm0_data, 32'hdead_beef);
        tick(); drive_idle();
        chk_val("cm_alloc_free", 32'(bus.free_rrf), 32'h0000_009f);
        chk_val("cm_alloc_err", 32'(bus.err), 32'h0);
        chk_val("cm_rd_valid", 32'(bus.rd0_valid), 32'h0);

        // alloc of busy tag 1
        bus.alloc0_en = 1'b1; bus.alloc0_tag = 3'd1;
        tick(); drive_idle();
        chk_val("alloc_busy_err", 32'(bus.err), 32'h1);
        chk_val("alloc_busy_free", 32'(bus.free_rrf), 32'h0000_009f);
        tick(); drive_idle();
        chk_val("alloc_busy_err_clr", 32'(bus.err), 32'h0);

        // writeback to free tag 5
        bus.wb0_en = 1'b1; bus.wb0_tag = 3'd5; bus.wb0_data = 32'h1234_5678;
        bus.rd0_tag = 3'd5;
        #1;
        chk_val("wb_free_byp", 32'(bus.rd0_valid), 32'h0);
        tick(); drive_idle();
        chk_val("wb_free_err", 32'(bus.err), 32'h1);
        chk_val("wb_free_free", 32'(bus.free_rrf), 32'h0000_009f);
        chk_val("wb_free_valid", 32'(bus.rd0_valid), 32'h0);
        tick(); drive_idle();
        chk_val("wb_free_err_clr", 32'(bus.err), 32'h0);

        // both writeback ports to tag 1: wb0 wins
        bus.wb0_en = 1'b1; bus.wb0_tag = 3'd1; bus.wb0_data = 32'haaaa_0001;
        bus.wb1_en = 1'b1; bus.wb1_tag = 3'd1; bus.wb1_data = 32'hbbbb_0002;
        bus.rd0_tag = 3'd1;
        #1;
        chk_val("dual_wb_byp", bus.rd0_data, 32'haaaa_0001);
        tick(); drive_idle();
        chk_val("dual_wb_err", 32'(bus.err), 32'h1);
        chk_val("dual_wb_data", bus.rd0_data, 32'haaaa_0001);

        // commit of allocated-but-not-valid tag 2
        bus.cm0_en = 1'b1; bus.cm0_tag = 3'd2;
        tick(); drive_idle();
        chk_val("cm_nv_err", 32'(bus.err), 32'h1);
        chk_val("cm_nv_free", 32'(bus.free_rrf), 32'h0000_009f);
        tick(); drive_idle();
        chk_val("cm_nv_err_clr", 32'(bus.err), 32'h0);

        // both alloc slots on tag 3
        bus.alloc0_en = 1'b1; bus.alloc0_tag = 3'd3;
        bus.alloc1_en = 1'b1; bus.alloc1_tag = 3'd3;
        tick(); drive_idle();
        chk_val("dual_alloc_err", 32'(bus.err), 32'h1);
        chk_val("dual_alloc_free", 32'(bus.free_rrf), 32'h0000_008f);

        // fill remaining entries
        bus.alloc0_en = 1'b1; bus.alloc0_tag = 3'd0;
        bus.alloc1_en = 1'b1; bus.alloc1_tag = 3'd4;
        tick(); drive_idle();
        chk_val("fill1_free", 32'(bus.free_rrf), 32'h0000_0007);
        chk_val("fill1_err", 32'(bus.err), 32'h0);
        bus.alloc0_en = 1'b1; bus.alloc0_tag = 3'd5;
        bus.alloc1_en = 1'b1; bus.alloc1_tag = 3'd6;
        tick(); drive_idle();
        chk_val("fill2_free", 32'(bus.free_rrf), 32'h0000_0001);
        bus.alloc0_en = 1'b1; bus.alloc0_tag = 3'd7;
        tick(); drive_idle();
        chk_val("full_free", 32'(bus.free_rrf), 32'h0000_0000);

        // flush with concurrent wb / commit / illegal alloc
        bus.flush = 1'b1;
        bus.wb0_en = 1'b1; bus.wb0_tag = 3'd2; bus.wb0_data = 32'h0000_0055;
        bus.cm0_en = 1'b1; bus.cm0_tag = 3'd1;
        bus.alloc0_en = 1'b1; bus.alloc0_tag = 3'd3;
        tick(); drive_idle();
        chk_val("flush_free", 32'(bus.free_rrf), 32'h0000_00ff);
        chk_val("flush_err", 32'(bus.err), 32'h0);
        for (int t = 0; t < 4; t++) begin
            bus.rd0_tag = 3'(t);
            bus.rd1_tag = 3'(t + 4);
            #1;
            chk_val("flush_rd0_valid", 32'(bus.rd0_valid), 32'h0);
            chk_val("flush_rd1_valid", 32'(bus.rd1_valid), 32'h0);
        end

        // independent ops on different tags in one cycle
        bus.alloc0_en = 1'b1; bus.alloc0_tag = 3'd6;
        bus.alloc1_en = 1'b1; bus.alloc1_tag = 3'd7;
        tick(); drive_idle();
        chk_val("alloc67_free", 32'(bus.free_rrf), 32'h0000_00fc);
        bus.alloc0_en = 1'b1; bus.alloc0_tag = 3'd0;
        bus.wb0_en = 1'b1; bus.wb0_tag = 3'd7; bus.wb0_data = 32'h0000_0077;
        bus.wb1_en = 1'b1; bus.wb1_tag = 3'd6; bus.wb1_data = 32'hcafe_f00d;
        bus.rd0_tag = 3'd7; bus.rd1_tag = 3'd6;
        #1;
        chk_val("byp1_valid", 32'(bus.rd1_valid), 32'h1);
        chk_val("byp1_data", bus.rd1_data, 32'hcafe_f00d);
        chk_val("byp0_data", bus.rd0_data, 32'h0000_0077);
        tick(); drive_idle();
        chk_val("multi_free", 32'(bus.free_rrf), 32'h0000_007c);
        chk_val("multi_err", 32'(bus.err), 32'h0);
        chk_val("multi_rd1_data", bus.rd1_data, 32'hcafe_f00d);
        chk_val("multi_rd0_valid", 32'(bus.rd0_valid), 32'h1);

        // dual commit of tags 6 and 7
        bus.cm0_en = 1'b1; bus.cm0_tag = 3'd6;
        bus.cm1_en = 1'b1; bus.cm1_tag = 3'd7;
        #1;
        chk_val("cm0_data_6", bus.cm0_data, 32'hcafe_f00d);
        chk_val("cm1_data_7", bus.cm1_data, 32'h0000_0077);
        tick(); drive_idle();
        chk_val("dual_cm_free", 32'(bus.free_rrf), 32'h0000_007f);
        chk_val("dual_cm_err", 32'(bus.err), 32'h0);

        // asynchronous reset in the middle of a cycle
        #2;
        rst = 1'b1;
        #1;
        chk_val("async_rst_free", 32'(bus.free_rrf), 32'h0000_00ff);
        chk_val("async_rst_err", 32'(bus.err), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive_idle();
        chk_val("post_rst_free", 32'(bus.free_rrf), 32'h0000_00ff);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/rrf_state_table.md
# rrf_state_table

Rename register file (RRF) state and storage for the dual-issue out-of-order core. Holds busy/valid/data for 8 rename registers and produces the `free_rrf` vector consumed by the rename picker, which returns two free tags to dispatch. Accepts up to 2 allocations (dispatch), 2 result writebacks (execution units) and 2 releases (commit) per cycle, and serves 2 operand lookups with writeback bypass.

## Interface
- NUM_RRF, 8, number of rename registers
- TAG_W, 3, tag width (log2 NUM_RRF)
- DATA_W, 32, result data width

- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- free_rrf  out  [0:NUM_RRF-1]  bit j = 1 when entry j is not busy
- alloc0_en / alloc1_en  in  1  allocate request, dispatch slot 0 / 1
- alloc0_tag / alloc1_tag  in  TAG_W  entry to allocate
- wb0_en / wb1_en  in  1  result writeback strobe, execution port 0 / 1
- wb0_tag / wb1_tag  in  TAG_W  destination entry
- wb0_data / wb1_data  in  DATA_W  result
- cm0_en / cm1_en  in  1  commit release, retire slot 0 / 1
- cm0_tag / cm1_tag  in  TAG_W  entry being retired
- cm0_data / cm1_data  out  DATA_W  combinational data of committed entry (to ARF)
- rd0_tag / rd1_tag  in  TAG_W  operand lookup tag
- rd0_valid / rd1_valid  out  1  operand value available
- rd0_data / rd1_data  out  DATA_W  operand value
- flush  in  1  squash all in-flight renames
- err  out  1  registered one-cycle pulse on any illegal request

## Operation
- Per entry: busy, valid, data[DATA_W]. Reset: busy=0, valid=0, data=0; free_rrf all ones; err=0.
- Alloc (edge): busy=1, valid=0. Alloc to busy entry: ignored, err. alloc0_tag==alloc1_tag with both enabled: slot 0 applied, err.
- Writeback (edge): entry busy and not valid -> valid=1, data stored. WB to non-busy or already-valid entry: ignored, err. Both WB ports same tag: wb0 applied, err.
- Commit: cmN_data = data[cmN_tag] combinationally; at edge busy=0, valid=0 (data retained). Commit of non-valid entry: ignored, err. Both commits same tag: one release, err.
- Same-cycle same-tag conflicts: commit + alloc -> commit applied, alloc ignored, err; writeback + alloc -> alloc applied, wb ignored, err; writeback + commit -> commit ignored (entry not yet valid), wb applied, err.
- Different tags: all six operations apply independently in one cycle.
- Lookup: rdN_valid = valid[tag] | (wbX_en & wbX_tag==tag & entry busy); data from matching wb port (wb0 priority), else stored data. rdN_valid=0 for non-busy entry.
- flush (edge): busy=0, valid=0 for all entries; overrides alloc/wb/commit that cycle; err=0 next cycle.
- Reset asserted mid-operation: all state cleared immediately, independent of clk.

## Timing
- free_rrf driven only from busy flops (no input combinational path): alloc at edge k clears bit after edge k; commit at edge k sets bit after edge k. Picker output therefore never re-offers a tag allocated in the same cycle.
- Writeback to dependent operand: 0-cycle via bypass; stored after the edge.
- cmN_data, rdN_* : combinational, same cycle as tag.
- err: registered, asserted the cycle after the offending request, one cycle wide per offending cycle.

## Structure
- Shared package rrf_pkg: NUM_RRF, TAG_W, DATA_W, tag type.
- Sub-module rrf_entry: one entry's busy/valid/data flops plus its alloc/wb/commit/flush update and per-entry error flag; instantiated NUM_RRF times. Top level does tag decode, conflict detection, read muxes and bypass.

## Test plan
- Reset then idle -> free_rrf=8'b1111_1111, err=0, rd0_valid=0 for all tags.
- Alloc tags 0,1 at edge 1; wb0 tag 0 data 0xDEADBEEF at edge 3 -> free_rrf=0011_1111 after edge 1; rd0_tag=0 shows valid=1, data=0xDEADBEEF in cycle 3 (bypass) and after.
- Commit tag 0 and alloc tag 2 same cycle -> cm0_data=0xDEADBEEF; after edge free_rrf bit0=1, bit2=0; err=0.
- Alloc busy tag 1 again; wb to free tag 5 -> state unchanged, err=1 for exactly one cycle each.
- Fill all 8 entries, then flush with concurrent alloc/wb -> free_rrf=all ones next cycle, no entry valid.
- Assert rst asynchronously mid-cycle with entries busy -> free_rrf all ones before next clk edge.
